a2_pipeline_controller: RTL and testbench
=========================================

A2_PIPELINE_CONTROLLER -- requirements
Module: a2_pipeline_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; sampled on the clk rising edge.
REQ-004 start  input  1  single-cycle request to begin execution from pc 0.
REQ-005 instr_valid  input  1  instruction memory presents a valid instr.
REQ-006 instr  input  8  fields: [7:6] opcode (00 ADD, 01 SE, 10 NOP, 11 HALT), [5:3] rd, [2:0] rs1 or immediate.
REQ-007 instr_ready  output  1  controller accepts instr this cycle.
REQ-008 pc  output  8  fetch address.
REQ-009 id_valid, id_SEtoReg, id_WriteReg  output  1 each  ID/EX control bits.
REQ-010 id_rs1, id_rd, id_imm  output  3 each  ID/EX register fields and unextended immediate.
REQ-011 ex_valid, ex_SEtoReg, ex_WriteReg  output  1 each  EX/WB control bits.
REQ-012 ex_rd  output  3  EX/WB destination register.
REQ-013 wb_valid  output  1  an instruction completes writeback this cycle.
REQ-014 state  output  2  00 IDLE, 01 RUN, 10 DRAIN, 11 HALTED.
REQ-015 retired  output  8  count of retired ADD/SE instructions.

Function
REQ-016 An instruction SHALL be accepted on a cycle where instr_valid and instr_ready are both 1.
REQ-017 instr_ready SHALL be 1 only in RUN.
REQ-018 On acceptance, pc SHALL increment by 1 modulo 256 (0xFF -> 0x00).
REQ-019 An instruction accepted at cycle N SHALL appear with id_valid=1 at N+1, ex_valid=1 at N+2 and wb_valid=1 at N+3.
REQ-020 A cycle in RUN without acceptance SHALL insert a bubble: id_valid=0 in the next cycle, with the bubble propagating to EX and WB.
REQ-021 Decode: ADD -> SEtoReg=0, WriteReg=1; SE -> SEtoReg=1, WriteReg=1; NOP and HALT -> WriteReg=0, SEtoReg=0.
REQ-022 Fields SHALL be decoded as id_rd=instr[5:3], id_rs1=instr[2:0] and id_imm=instr[2:0].
REQ-023 id_WriteReg and ex_WriteReg SHALL be 0 whenever the corresponding valid bit is 0.
REQ-024 EX/WB fields (ex_SEtoReg, ex_WriteReg, ex_rd, ex_valid) SHALL be registered copies of the ID/EX fields with one cycle of latency.
REQ-025 wb_valid SHALL be the registered copy of ex_valid AND ex_WriteReg.
REQ-026 retired SHALL increment by 1 on each cycle with wb_valid=1, and SHALL saturate at 0xFF.
REQ-027 IDLE -> RUN on start=1; the same transition SHALL set pc=0 and clear retired.
REQ-028 RUN -> DRAIN on acceptance of a HALT instruction; HALT does not advance pc.
REQ-029 DRAIN -> HALTED on the first cycle in which id_valid, ex_valid and wb_valid are all 0.
REQ-030 HALTED -> RUN on start=1, with pc=0 and retired cleared.
REQ-031 start SHALL be ignored in RUN and DRAIN, including a start that coincides with HALT acceptance.
REQ-032 instr_valid and instr SHALL be ignored outside RUN.

Reset
REQ-033 On reset=1: state=IDLE, pc=0, retired=0, and all valid bits and WriteReg bits SHALL be 0.
REQ-034 On reset=1: id_SEtoReg, ex_SEtoReg, id_rs1, id_rd, id_imm and ex_rd SHALL be 0.
REQ-035 Reset SHALL take priority over start and instruction acceptance in the same cycle.
REQ-036 Reset mid-operation SHALL discard all in-flight instructions; no wb_valid SHALL assert after a reset until a new start is given.

Verification
REQ-037 Basic flow: reset, then start, then instr=0x4E (SE rd=1 imm=6) valid -> id_valid, id_SEtoReg=1, id_rd=1, id_imm=6 next cycle; wb_valid 3 cycles after accept; retired=1; pc=1.
REQ-038 Back-to-back: ADD 0x08 (rd=1, rs1=0) then ADD 0x09 -> consecutive wb_valid pulses; ex_rd=1 in both; no bubbles.
REQ-039 Bubble: instr_valid=0 for one cycle between two SE instructions -> a single id_valid=0 gap that propagates to ex_valid and wb_valid; pc advances only twice.
REQ-040 Halt drain: SE, NOP, HALT (0xC0) -> state=DRAIN after the HALT, HALTED 3 cycles later; retired=1; instr_ready=0 throughout DRAIN; start during DRAIN ignored.
REQ-041 Wrap and saturate: run 300 SE instructions -> pc wraps 0xFF->0x00; retired holds at 0xFF.
REQ-042 Mid-run reset: assert reset while ex_valid=1 -> next cycle state=IDLE, all valid bits 0, pc=0; no wb_valid pulse follows.

Source files
------------

// File: rtl/a2_pipeline_controller_if.sv
// Fetch-side handshake between instruction memory and the A2 pipeline controller.
interface a2_pipeline_controller_if;
  logic       instr_valid;
  logic [7:0] instr;
  logic       instr_ready;
  logic [7:0] pc;

  modport master (output instr_valid, output instr, input instr_ready, input pc);
  modport slave  (input instr_valid, input instr, output instr_ready, output pc);
endinterface

// File: rtl/a2_pipeline_controller.sv
// Three-stage (ID/EX/WB) control pipeline with fetch handshake, run/drain/halt
// sequencing and a saturating retired-instruction counter.
module a2_pipeline_controller (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  a2_pipeline_controller_if.slave        fetch,
  output logic                           id_valid,
  output logic                           id_SEtoReg,
  output logic                           id_WriteReg,
  output logic [2:0]                     id_rs1,
  output logic [2:0]                     id_rd,
  output logic [2:0]                     id_imm,
  output logic                           ex_valid,
  output logic                           ex_SEtoReg,
  output logic                           ex_WriteReg,
  output logic [2:0]                     ex_rd,
  output logic                           wb_valid,
  output logic [1:0]                     state,
  output logic [7:0]                     retired
);

  localparam int unsigned PC_W = 8;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SE   = 2'b01;
  localparam logic [1:0] OP_HALT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_DRAIN  = 2'b10,
    S_HALTED = 2'b11
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              ready_q;
  logic              restart;
  logic              accept;
  logic [1:0]        op;
  logic [PC_W-1:0]   pc_q;

  assign op                = fetch.instr[7:6];
  assign accept            = ready_q & fetch.instr_valid;
  assign fetch.instr_ready = ready_q;
  assign fetch.pc          = pc_q;
  assign state             = state_q;

  // Next-state logic; restart marks the IDLE/HALTED -> RUN transition.
  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_d = S_RUN;
          restart = 1'b1;
        end
      end
      S_RUN: begin
        if (accept && (op == OP_HALT)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!id_valid && !ex_valid && !wb_valid) state_d = S_HALTED;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ready is kept as a register that tracks "state is RUN".
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == S_RUN);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      retired <= '0;
    end else if (restart) begin
      pc_q    <= '0;
      retired <= '0;
    end else begin
      if (accept && (op != OP_HALT)) pc_q <= pc_q + PC_W'(1);
      if (wb_valid && (retired != 8'hFF)) retired <= retired + 8'd1;
    end
  end

  // ID/EX stage: a non-accepting cycle becomes a bubble with write disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid    <= 1'b0;
      id_SEtoReg  <= 1'b0;
      id_WriteReg <= 1'b0;
      id_rs1      <= '0;
      id_rd       <= '0;
      id_imm      <= '0;
    end else begin
      id_valid    <= accept;
      id_SEtoReg  <= accept && (op == OP_SE);
      id_WriteReg <= accept && ((op == OP_ADD) || (op == OP_SE));
      if (accept) begin
        id_rd  <= fetch.instr[5:3];
        id_rs1 <= fetch.instr[2:0];
        id_imm <= fetch.instr[2:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_SEtoReg  <= 1'b0;
      ex_WriteReg <= 1'b0;
      ex_rd       <= '0;
      wb_valid    <= 1'b0;
    end else begin
      ex_valid    <= id_valid;
      ex_SEtoReg  <= id_SEtoReg;
      ex_WriteReg <= id_WriteReg;
      ex_rd       <= id_rd;
      wb_valid    <= ex_valid & ex_WriteReg;
    end
  end

endmodule

// File: tb/tb_a2_pipeline_controller.sv
// Directed bench for a2_pipeline_controller: an age-indexed model of accepted
// instructions checked every cycle, plus hand-computed literal checkpoints.
module tb_a2_pipeline_controller;

  logic       clk;
  logic       reset;
  logic       start;
  logic       id_valid, id_SEtoReg, id_WriteReg;
  logic [2:0] id_rs1, id_rd, id_imm;
  logic       ex_valid, ex_SEtoReg, ex_WriteReg;
  logic [2:0] ex_rd;
  logic       wb_valid;
  logic [1:0] state;
  logic [7:0] retired;

  int n_vec = 0;
  int n_err = 0;

  a2_pipeline_controller_if fi ();

  a2_pipeline_controller dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .fetch       (fi),
    .id_valid    (id_valid),
    .id_SEtoReg  (id_SEtoReg),
    .id_WriteReg (id_WriteReg),
    .id_rs1      (id_rs1),
    .id_rd       (id_rd),
    .id_imm      (id_imm),
    .ex_valid    (ex_valid),
    .ex_SEtoReg  (ex_SEtoReg),
    .ex_WriteReg (ex_WriteReg),
    .ex_rd       (ex_rd),
    .wb_valid    (wb_valid),
    .state       (state),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit writes(input logic [7:0] i);
    return (i[7:6] == 2'b00) || (i[7:6] == 2'b01);
  endfunction

  function automatic bit is_se(input logic [7:0] i);
    return i[7:6] == 2'b01;
  endfunction

  // Model: hv/hi[k] hold the instruction accepted k cycles ago (1=ID, 2=EX, 3=WB).
  bit         m_known = 1'b0;
  int         m_state;
  int         m_pc;
  int         m_ret;
  bit         hv [1:3];
  logic [7:0] hi [1:3];

  always @(negedge clk) begin
    bit wb_now;
    bit acc;
    bit restart;
    if (m_known) begin
      wb_now = hv[3] && writes(hi[3]);
      chk("state",       state,       8'(m_state));
      chk("pc",          fi.pc,       8'(m_pc));
      chk("retired",     retired,     8'(m_ret));
      chk("instr_ready", fi.instr_ready, 8'(m_state == 1));
      chk("id_valid",    id_valid,    8'(hv[1]));
      chk("id_WriteReg", id_WriteReg, 8'(hv[1] && writes(hi[1])));
      chk("ex_valid",    ex_valid,    8'(hv[2]));
      chk("ex_WriteReg", ex_WriteReg, 8'(hv[2] && writes(hi[2])));
      chk("wb_valid",    wb_valid,    8'(wb_now));
      if (hv[1]) begin
        chk("id_SEtoReg", id_SEtoReg, 8'(is_se(hi[1])));
        chk("id_rd",      id_rd,      8'(hi[1][5:3]));
        chk("id_rs1",     id_rs1,     8'(hi[1][2:0]));
        chk("id_imm",     id_imm,     8'(hi[1][2:0]));
      end
      if (hv[2]) begin
        chk("ex_SEtoReg", ex_SEtoReg, 8'(is_se(hi[2])));
        chk("ex_rd",      ex_rd,      8'(hi[2][5:3]));
      end
    end
    if (reset) begin
      m_known = 1'b1;
      m_state = 0;
      m_pc    = 0;
      m_ret   = 0;
      for (int k = 1; k <= 3; k++) begin
        hv[k] = 1'b0;
        hi[k] = 8'h00;
      end
    end else if (m_known) begin
      wb_now  = hv[3] && writes(hi[3]);
      acc     = (m_state == 1) && (fi.instr_valid === 1'b1);
      restart = ((m_state == 0) || (m_state == 3)) && (start === 1'b1);
      if (restart) m_state = 1;
      else if (acc && (fi.instr[7:6] == 2'b11)) m_state = 2;
      else if ((m_state == 2) && !hv[1] && !hv[2] && !wb_now) m_state = 3;
      if (restart) begin
        m_pc  = 0;
        m_ret = 0;
      end else begin
        if (acc && (fi.instr[7:6] != 2'b11)) m_pc = (m_pc + 1) % 256;
        if (wb_now && (m_ret < 255)) m_ret = m_ret + 1;
      end
      hv[3] = hv[2]; hi[3] = hi[2];
      hv[2] = hv[1]; hi[2] = hi[1];
      hv[1] = acc;   hi[1] = fi.instr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] ins);
    fi.instr_valid = 1'b1;
    fi.instr       = ins;
    tick();
    fi.instr_valid = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    fi.instr_valid = 1'b0;
    fi.instr = 8'h00;
    ticks(2);
    chk("rst_state",   state,    8'h00);
    chk("rst_pc",      fi.pc,    8'h00);
    chk("rst_retired", retired,  8'h00);
    chk("rst_id_v",    id_valid, 8'h00);
    chk("rst_id_rd",   id_rd,    8'h00);
    reset = 1'b0;
    tick();

    // Basic SE flow
    do_start();
    chk("run_state", state, 8'h01);
    issue(8'h4E);
    chk("basic_id_valid", id_valid,   8'h01);
    chk("basic_id_se",    id_SEtoReg, 8'h01);
    chk("basic_id_rd",    id_rd,      8'h01);
    chk("basic_id_imm",   id_imm,     8'h06);
    chk("basic_pc",       fi.pc,      8'h01);
    ticks(2);
    chk("basic_wb", wb_valid, 8'h01);
    tick();
    chk("basic_retired", retired, 8'h01);

    // Back-to-back ADDs
    issue(8'h08);
    issue(8'h09);
    tick();
    chk("b2b_wb0", wb_valid, 8'h01);
    chk("b2b_exrd", ex_rd, 8'h01);
    tick();
    chk("b2b_wb1", wb_valid, 8'h01);
    chk("b2b_pc", fi.pc, 8'h03);

    // Single bubble between two SEs
    issue(8'h4A);
    tick();
    issue(8'h53);
    chk("bub_pc", fi.pc, 8'h05);
    ticks(3);
    chk("bub_retired", retired, 8'h05);

    // Drain with start held across HALT acceptance
    issue(8'h4F);
    issue(8'h80);
    start = 1'b1;
    issue(8'hC0);
    chk("drain_state", state, 8'h02);
    chk("drain_ready", fi.instr_ready, 8'h00);
    chk("drain_pc", fi.pc, 8'h07);
    ticks(2);
    chk("drain_state2", state, 8'h02);
    start = 1'b0;
    tick();
    chk("halted_state", state, 8'h03);
    chk("halted_retired", retired, 8'h06);

    // Fresh run: SE, NOP, HALT
    do_start();
    issue(8'h4E);
    issue(8'h80);
    issue(8'hC0);
    chk("drain2_state", state, 8'h02);
    ticks(3);
    chk("halted2_state", state, 8'h03);
    chk("halted2_retired", retired, 8'h01);

    // 300 SEs: pc wrap and retired saturation
    do_start();
    for (int i = 0; i < 300; i++) begin
      issue(8'h4E);
      if (i == 255) chk("wrap_pc0", fi.pc, 8'h00);
    end
    chk("wrap_pc_end", fi.pc, 8'h2C);
    ticks(4);
    chk("sat_retired", retired, 8'hFF);

    // Reset with an instruction in EX
    issue(8'h4E);
    tick();
    chk("mid_ex_valid", ex_valid, 8'h01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_state", state,    8'h00);
    chk("mid_id_v",  id_valid, 8'h00);
    chk("mid_ex_v",  ex_valid, 8'h00);
    chk("mid_wb_v",  wb_valid, 8'h00);
    chk("mid_pc",    fi.pc,    8'h00);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mid_no_wb", wb_valid, 8'h00);
    end

    // Reset beats start; instructions ignored while IDLE
    reset = 1'b1;
    start = 1'b1;
    fi.instr_valid = 1'b1;
    fi.instr = 8'h4E;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("rst_prio_state", state, 8'h00);
    ticks(3);
    fi.instr_valid = 1'b0;
    chk("idle_id_v", id_valid, 8'h00);
    chk("idle_pc",   fi.pc,    8'h00);
    ticks(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
